alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
// - Operand-fetch stage directly upstream of the ALU: holds the 32-entry integer register file,
//   reads rs1/rs2 for a decoded instruction, and registers the ALU operands and sel into an ID/EX register.
// - A per-register pending scoreboard stalls issue while a source register still awaits writeback (RAW hazard).
// - The writeback port is driven by the stage after the ALU, which returns sal as wb_data.
// PARAMETERS
// - XLEN   32  datapath width (ALU operand/result width)
// - NREG   32  number of architectural registers; x0 hardwired to zero
// - AW     5   register address width, equals clog2(NREG)
// - SELW   3   ALU operation-select width
// PORTS
// - clk        in   1     single clock; all state updates on posedge
// - rst_n      in   1     reset, asynchronous, active-low
// - in_valid   in   1     decoded instruction present
// - in_ready   out  1     stage accepts the instruction this cycle
// - rs1_addr   in   AW    source 1 register index
// - rs2_addr   in   AW    source 2 register index
// - rd_addr    in   AW    destination index (0 = no destination)
// - alu_sel    in   SELW  ALU operation, passed through to ex_sel
// - use_imm    in   1     1: operand 2 = imm, rs2 is not read and not hazard-checked
// - imm        in   XLEN  sign-extended immediate from decode
// - wb_en      in   1     writeback strobe
// - wb_addr    in   AW    writeback register index
// - wb_data    in   XLEN  writeback value (ALU sal)
// - ex_valid   out  1     ALU operands valid
// - ex_ready   in   1     ALU/downstream consumes the current operands
// - ex_rs1     out  XLEN  ALU rs1 operand
// - ex_rs2     out  XLEN  ALU rs2 operand (register or imm)
// - ex_sel     out  SELW  ALU sel
// - ex_rd      out  AW    destination index, carried forward for writeback
// BEHAVIOUR
// - Reset (rst_n=0, asynchronous): all registers = 0, scoreboard clear, ex_valid=0, ex_rs1/ex_rs2/ex_sel/ex_rd=0.
//   Any in-flight instruction is dropped. Outputs are held while rst_n=0.
// - Register file: synchronous write on posedge when wb_en=1 and wb_addr!=0. Writes to x0 are ignored.
//   Reads are combinational. x0 always reads 0.
// - Write bypass: if wb_en=1, wb_addr==rsN, and rsN!=0, operand N takes wb_data in the same cycle.
// - Hazard (combinational): hz = (pend[rs1_addr] & ~clr1) | (~use_imm & pend[rs2_addr] & ~clr2).
//   clrN = (wb_en and wb_addr==rsN). pend[0] is always 0.
// - in_ready = (~ex_valid | ex_ready) & ~hz. The stage accepts when in_valid & in_ready.
// - Accept: next cycle ex_valid=1, and ex_* take the fetched operands, sel, and rd. Issue latency is 1 cycle.
// - No accept and ex_ready=1: ex_valid -> 0. The data outputs keep their last values.
// - Stall (ex_valid=1, ex_ready=0): all ex_* hold stable. A writeback during the stall does not alter captured operands.
// - Scoreboard, per cycle:
//   - wb_en with wb_addr!=0 clears pend[wb_addr].
//   - An accept with rd_addr!=0 sets pend[rd_addr].
//   - Same register in both: set wins.
//   - wb to a non-pending register: plain write, no error.
// - Widths: all operands are XLEN. No arithmetic is done in this block. imm is passed unmodified.
// STRUCTURE
// - Shared package rv_pkg: XLEN, AW, NREG, SELW, and ALU sel encodings (ALU_ADD=0 ... 7).
// - One sub-module: rv_regfile (2 combinational read ports, 1 sync write port, x0 = 0, write bypass, async active-low clear).
// - Scoreboard, hazard logic, and the ID/EX register stay in this module.
// TESTING
// - Load and issue:
//   - wb x5=226, then wb x6=7.
//   - Issue rs1=5, rs2=6, sel=2, rd=9.
//   - Next cycle: ex_valid=1, ex_rs1=226, ex_rs2=7, ex_sel=2, ex_rd=9.
// - Bypass: wb x7=0x55 in the same cycle as issuing rs1=7 -> ex_rs1=0x55. A later read of x7 also gives 0x55.
// - x0: wb x0=0xFFFFFFFF, then issue rs1=0, rs2=0 -> ex_rs1=0, ex_rs2=0. pend[0] never sets.
// - RAW stall:
//   - Issue rd=8, then issue rs1=8 -> in_ready=0.
//   - Once wb x8=9, in_ready=1 that same cycle, the instruction is accepted, and ex_rs1=9.
//   - use_imm=1 with rs2=8 pending is accepted immediately, with ex_rs2=imm.
// - Backpressure: ex_valid=1 with ex_ready=0 for 3 cycles -> ex_* unchanged and in_ready=0. Raise ex_ready -> the next instruction is taken.
// - Reset mid-operation:
//   - Drop rst_n while ex_valid=1 and pend[8]=1 -> ex_valid=0 immediately, pend cleared.
//   - After release, issue rs1=5 -> ex_rs1=0.

Source files
------------

// File: rtl/rv_pkg.sv
// rv_pkg: shared widths and ALU select encodings for the integer pipeline
package rv_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int SELW = 3;

    typedef enum logic [SELW-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SRA = 3'd7
    } alu_sel_e;
endpackage

// File: rtl/rv_regfile.sv
// rv_regfile: 2-read/1-write register file, x0 reads zero, writeback bypassed onto reads
module rv_regfile
    import rv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd
);
    logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;

    // write port; x0 is never written so it stays zero
    always_comb begin
        regs_d = regs_q;
        if (we && wa != '0) regs_d[wa] = wd;
    end

    // read ports with same-cycle writeback bypass
    always_comb begin
        rd1 = (ra1 == '0) ? '0 : (we && wa == ra1) ? wd : regs_q[ra1];
        rd2 = (ra2 == '0) ? '0 : (we && wa == ra2) ? wd : regs_q[ra2];
    end

    // register storage, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) regs_q <= '0;
        else        regs_q <= regs_d;
    end
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: operand fetch with RAW scoreboard and ID/EX register feeding the ALU
module alu_operand_stage
    import rv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic [AW-1:0]   rd_addr,
    input  logic [SELW-1:0] alu_sel,
    input  logic            use_imm,
    input  logic [XLEN-1:0] imm,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_rs1,
    output logic [XLEN-1:0] ex_rs2,
    output logic [SELW-1:0] ex_sel,
    output logic [AW-1:0]   ex_rd
);
    logic [XLEN-1:0] rd1, rd2;
    logic [NREG-1:0] pend_q, pend_d;
    logic            ex_valid_q, ex_valid_d;
    logic [XLEN-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
    logic [SELW-1:0] ex_sel_q, ex_sel_d;
    logic [AW-1:0]   ex_rd_q, ex_rd_d;
    logic            clr1, clr2, hz, acc;

    rv_regfile u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (rs1_addr),
        .ra2   (rs2_addr),
        .rd1   (rd1),
        .rd2   (rd2),
        .we    (wb_en),
        .wa    (wb_addr),
        .wd    (wb_data)
    );

    // RAW hazard: a pending source stalls unless its writeback arrives this cycle
    always_comb begin
        clr1     = wb_en && wb_addr == rs1_addr;
        clr2     = wb_en && wb_addr == rs2_addr;
        hz       = (pend_q[rs1_addr] & ~clr1) | (~use_imm & pend_q[rs2_addr] & ~clr2);
        in_ready = (~ex_valid_q | ex_ready) & ~hz;
        acc      = in_valid & in_ready;
    end

    // scoreboard: writeback clears, accept sets, set wins on the same register
    always_comb begin
        pend_d = pend_q;
        if (wb_en && wb_addr != '0) pend_d[wb_addr] = 1'b0;
        if (acc && rd_addr != '0) pend_d[rd_addr] = 1'b1;
    end

    // ID/EX register: load on accept, otherwise hold data and drain valid when consumed
    always_comb begin
        ex_valid_d = acc | (ex_valid_q & ~ex_ready);
        ex_rs1_d   = acc ? rd1 : ex_rs1_q;
        ex_rs2_d   = acc ? (use_imm ? imm : rd2) : ex_rs2_q;
        ex_sel_d   = acc ? alu_sel : ex_sel_q;
        ex_rd_d    = acc ? rd_addr : ex_rd_q;
    end

    // state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= '0;
            ex_valid_q <= 1'b0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
            ex_sel_q   <= '0;
            ex_rd_q    <= '0;
        end else begin
            pend_q     <= pend_d;
            ex_valid_q <= ex_valid_d;
            ex_rs1_q   <= ex_rs1_d;
            ex_rs2_q   <= ex_rs2_d;
            ex_sel_q   <= ex_sel_d;
            ex_rd_q    <= ex_rd_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_rs1   = ex_rs1_q;
    assign ex_rs2   = ex_rs2_q;
    assign ex_sel   = ex_sel_q;
    assign ex_rd    = ex_rd_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed vectors against a behavioural register/scoreboard model
module tb_alu_operand_stage;
    logic        clk = 0, rst_n = 0;
    logic        in_valid = 0, in_ready, use_imm = 0, wb_en = 0, ex_valid, ex_ready = 1;
    logic [4:0]  rs1_addr = 0, rs2_addr = 0, rd_addr = 0, wb_addr = 0, ex_rd;
    logic [2:0]  alu_sel = 0, ex_sel;
    logic [31:0] imm = 0, wb_data = 0, ex_rs1, ex_rs2;

    int tests = 0, fails = 0;

    logic [31:0] m_reg [32];
    bit          m_pend [32];
    logic        m_v;
    logic [31:0] m_e1, m_e2;
    logic [2:0]  m_sel;
    logic [4:0]  m_rd;

    alu_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr), .alu_sel(alu_sel),
        .use_imm(use_imm), .imm(imm), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_sel(ex_sel), .ex_rd(ex_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = 0;
            m_pend[i] = 0;
        end
        m_v = 0; m_e1 = 0; m_e2 = 0; m_sel = 0; m_rd = 0;
    endtask

    function automatic logic [31:0] rdv(input logic [4:0] r);
        if (r == 0) return 0;
        if (wb_en && wb_addr == r) return wb_data;
        return m_reg[r];
    endfunction

    function automatic bit busy(input logic [4:0] r);
        return m_pend[r] && !(wb_en && wb_addr == r);
    endfunction

    function automatic logic m_ready();
        return (!m_v || ex_ready) && !busy(rs1_addr) && (use_imm || !busy(rs2_addr));
    endfunction

    task automatic set_in(input logic iv, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd, input logic [2:0] sel, input logic ui,
                          input logic [31:0] im, input logic we, input logic [4:0] wa,
                          input logic [31:0] wd, input logic er);
        in_valid = iv; rs1_addr = r1; rs2_addr = r2; rd_addr = rd; alu_sel = sel;
        use_imm = ui; imm = im; wb_en = we; wb_addr = wa; wb_data = wd; ex_ready = er;
        #1;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic tick();
        logic acc;
        logic [31:0] o1, o2;
        acc = rst_n && in_valid && m_ready();
        o1 = rdv(rs1_addr);
        o2 = use_imm ? imm : rdv(rs2_addr);
        @(posedge clk);
        if (!rst_n) m_clear();
        else begin
            if (acc) begin
                m_v = 1; m_e1 = o1; m_e2 = o2; m_sel = alu_sel; m_rd = rd_addr;
            end else if (ex_ready) m_v = 0;
            if (wb_en && wb_addr != 0) begin
                m_reg[wb_addr] = wb_data;
                m_pend[wb_addr] = 0;
            end
            if (acc && rd_addr != 0) m_pend[rd_addr] = 1;
        end
        #1;
    endtask

    always @(negedge clk) begin
        chk("in_ready", {31'b0, in_ready}, {31'b0, m_ready()});
        chk("ex_valid", {31'b0, ex_valid}, {31'b0, m_v});
        chk("ex_rs1", ex_rs1, m_e1);
        chk("ex_rs2", ex_rs2, m_e2);
        chk("ex_sel", {29'b0, ex_sel}, {29'b0, m_sel});
        chk("ex_rd", {27'b0, ex_rd}, {27'b0, m_rd});
    end

    initial begin
        m_clear();
        idle();
        repeat (2) tick();
        chk("rst_ex_valid", {31'b0, ex_valid}, 0);
        chk("rst_ex_rs1", ex_rs1, 0);
        rst_n = 1;
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 5, 226, 1); tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 6, 7, 1); tick();
        set_in(1, 5, 6, 9, 2, 0, 0, 0, 0, 0, 1); tick();
        chk("issue_valid", {31'b0, ex_valid}, 1);
        chk("issue_rs1", ex_rs1, 226);
        chk("issue_rs2", ex_rs2, 7);
        chk("issue_sel", {29'b0, ex_sel}, 2);
        chk("issue_rd", {27'b0, ex_rd}, 9);
        set_in(1, 7, 0, 0, 1, 0, 0, 1, 7, 32'h55, 1); tick();
        chk("bypass_rs1", ex_rs1, 32'h55);
        set_in(1, 7, 5, 0, 1, 0, 0, 1, 9, 32'h100, 1); tick();
        chk("reread_x7", ex_rs1, 32'h55);
        chk("reread_x5", ex_rs2, 226);
        set_in(1, 0, 0, 0, 3, 0, 0, 1, 0, 32'hFFFFFFFF, 1); tick();
        chk("x0_rs1", ex_rs1, 0);
        chk("x0_rs2", ex_rs2, 0);
        set_in(1, 0, 0, 0, 3, 0, 0, 0, 0, 0, 1);
        chk("x0_never_pend", {31'b0, in_ready}, 1);
        tick();
        set_in(1, 0, 0, 8, 0, 0, 0, 0, 0, 0, 1); tick();
        set_in(1, 8, 0, 0, 5, 0, 0, 0, 0, 0, 1);
        chk("raw_stall", {31'b0, in_ready}, 0);
        tick(); tick();
        set_in(1, 8, 0, 0, 5, 0, 0, 1, 8, 9, 1);
        chk("raw_release", {31'b0, in_ready}, 1);
        tick();
        chk("raw_rs1", ex_rs1, 9);
        set_in(1, 0, 0, 8, 0, 0, 0, 0, 0, 0, 1); tick();
        set_in(1, 5, 8, 10, 6, 1, 32'hDEADBEEF, 0, 0, 0, 1);
        chk("imm_ready", {31'b0, in_ready}, 1);
        tick();
        chk("imm_rs2", ex_rs2, 32'hDEADBEEF);
        chk("imm_rs1", ex_rs1, 226);
        for (int i = 0; i < 3; i++) begin
            set_in(1, 5, 6, 0, 4, 0, 0, i == 0, 5, 32'h77, 0);
            chk("bp_ready", {31'b0, in_ready}, 0);
            tick();
            chk("bp_rs2_hold", ex_rs2, 32'hDEADBEEF);
            chk("bp_rs1_hold", ex_rs1, 226);
        end
        set_in(1, 5, 6, 0, 4, 0, 0, 0, 0, 0, 1);
        chk("bp_resume", {31'b0, in_ready}, 1);
        tick();
        chk("bp_rs1", ex_rs1, 32'h77);
        chk("bp_sel", {29'b0, ex_sel}, 4);
        idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 0;
        m_clear();
        #1;
        chk("async_rst_valid", {31'b0, ex_valid}, 0);
        tick();
        rst_n = 1;
        set_in(1, 5, 8, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_pend_clear", {31'b0, in_ready}, 1);
        tick();
        chk("rst_x5", ex_rs1, 0);
        idle(); tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
